// File: rtl/fft_bfly_pipe.sv
// Two-stage pipelined radix-2 butterfly: full-precision add/sub, then round,
// arithmetic shift and saturate, with a global stall-based valid/ready handshake.
module fft_bfly_pipe #(
  parameter int unsigned DW    = 16,
  parameter int unsigned LANES = 8,
  parameter int unsigned SHIFT = 4,
  parameter int unsigned RND   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*LANES*DW-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*LANES*DW-1:0]   out_data,
  input  logic                    ovf_clr,
  output logic                    ovf_sticky,
  output logic [15:0]             beat_cnt
);

  localparam int unsigned PW     = 2 * DW;
  localparam int unsigned NPTS   = 2 * LANES;
  localparam int unsigned BUSW   = 4 * LANES * DW;
  localparam int unsigned SW     = DW + 1;
  localparam int unsigned XW     = DW + 2;
  localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [XW-1:0] RND_ADD =
    ((RND != 0) && (SHIFT > 0)) ? (XW'(1) << RND_SH) : '0;
  localparam logic signed [XW-1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};

  logic                 w_adv;
  logic signed [SW-1:0] w_s1_re [NPTS];
  logic signed [SW-1:0] w_s1_im [NPTS];
  logic signed [SW-1:0] r_s1_re [NPTS];
  logic signed [SW-1:0] r_s1_im [NPTS];
  logic                 r_s1_valid;
  logic [DW:0]          w_sat_re [NPTS];
  logic [DW:0]          w_sat_im [NPTS];
  logic [BUSW-1:0]      w_s2_data;
  logic                 w_clip;
  logic [BUSW-1:0]      r_s2_data;
  logic                 r_s2_valid;
  logic                 r_ovf;
  logic [15:0]          r_cnt;

  function automatic logic signed [SW-1:0] sext(input logic [DW-1:0] v);
    return {v[DW-1], v};
  endfunction

  // Returns {clipped, result}: optional rounding, arithmetic shift, saturation.
  function automatic logic [DW:0] scale_sat(input logic signed [SW-1:0] v);
    logic signed [XW-1:0] ext;
    logic signed [XW-1:0] sh;
    ext = {v[SW-1], v};
    ext = ext + RND_ADD;
    sh  = ext >>> SHIFT;
    if (sh > SAT_MAX)      return {1'b1, SAT_MAX[DW-1:0]};
    else if (sh < SAT_MIN) return {1'b1, SAT_MIN[DW-1:0]};
    else                   return {1'b0, sh[DW-1:0]};
  endfunction

  assign w_adv = !r_s2_valid || out_ready;

  // Stage 1 combinational: sum to even point, difference to odd point.
  always_comb begin
    for (int j = 0; j < NPTS; j++) begin
      w_s1_re[j] = '0;
      w_s1_im[j] = '0;
    end
    for (int j = 0; j < LANES; j++) begin
      w_s1_re[2*j]   = sext(in_data[(2*j)*PW+DW +: DW]) + sext(in_data[(2*j+1)*PW+DW +: DW]);
      w_s1_im[2*j]   = sext(in_data[(2*j)*PW +: DW])    + sext(in_data[(2*j+1)*PW +: DW]);
      w_s1_re[2*j+1] = sext(in_data[(2*j)*PW+DW +: DW]) - sext(in_data[(2*j+1)*PW+DW +: DW]);
      w_s1_im[2*j+1] = sext(in_data[(2*j)*PW +: DW])    - sext(in_data[(2*j+1)*PW +: DW]);
    end
  end

  // Stage 2 combinational: scale every component and flag any clipping.
  always_comb begin
    w_s2_data = '0;
    w_clip    = 1'b0;
    for (int j = 0; j < NPTS; j++) begin
      w_sat_re[j] = scale_sat(r_s1_re[j]);
      w_sat_im[j] = scale_sat(r_s1_im[j]);
      w_s2_data[j*PW+DW +: DW] = w_sat_re[j][DW-1:0];
      w_s2_data[j*PW +: DW]    = w_sat_im[j][DW-1:0];
      w_clip = w_clip | w_sat_re[j][DW] | w_sat_im[j][DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NPTS; j++) begin
        r_s1_re[j] <= '0;
        r_s1_im[j] <= '0;
      end
      r_s1_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_adv) begin
        for (int j = 0; j < NPTS; j++) begin
          r_s1_re[j] <= w_s1_re[j];
          r_s1_im[j] <= w_s1_im[j];
        end
        r_s1_valid <= in_valid;
        r_s2_data  <= w_s2_data;
        r_s2_valid <= r_s1_valid;
      end
      // A new clip on a valid beat beats a simultaneous clear.
      if (w_adv && r_s1_valid && w_clip) r_ovf <= 1'b1;
      else if (ovf_clr)                  r_ovf <= 1'b0;
      if (r_s2_valid && out_ready) r_cnt <= r_cnt + 16'd1;
    end
  end

  assign in_ready   = w_adv;
  assign out_valid  = r_s2_valid;
  assign out_data   = r_s2_data;
  assign ovf_sticky = r_ovf;
  assign beat_cnt   = r_cnt;

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// Directed bench for fft_bfly_pipe: three instances (truncate, round, no-shift)
// driven in lockstep; vector table plus reset, overflow, stall and wrap sequences.
module tb_fft_bfly_pipe;

  localparam int unsigned DW    = 16;
  localparam int unsigned LANES = 8;
  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned BUSW  = 4 * LANES * DW;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [BUSW-1:0] in_data;
  logic            out_ready;
  logic            ovf_clr;

  logic            ir  [3];
  logic            ov  [3];
  logic [BUSW-1:0] od  [3];
  logic            ovf [3];
  logic [15:0]     cnt [3];

  int checks   = 0;
  int failures = 0;

  fft_bfly_pipe #(.DW(DW), .LANES(LANES), .SHIFT(4), .RND(0)) u_trunc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .ovf_clr(ovf_clr), .ovf_sticky(ovf[0]), .beat_cnt(cnt[0]));

  fft_bfly_pipe #(.DW(DW), .LANES(LANES), .SHIFT(4), .RND(1)) u_round (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .ovf_clr(ovf_clr), .ovf_sticky(ovf[1]), .beat_cnt(cnt[1]));

  fft_bfly_pipe #(.DW(DW), .LANES(LANES), .SHIFT(0), .RND(0)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .ovf_clr(ovf_clr), .ovf_sticky(ovf[2]), .beat_cnt(cnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned inst;
    logic [15:0] a_re, a_im, b_re, b_im;
    logic [15:0] s_re, s_im, d_re, d_im;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [BUSW-1:0] act, input logic [BUSW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BUSW-1:0] put(input logic [BUSW-1:0] bus, input int k,
                                          input logic [15:0] re, input logic [15:0] im);
    logic [BUSW-1:0] b;
    b = bus;
    b[k*PW +: PW] = {re, im};
    return b;
  endfunction

  function automatic logic [BUSW-1:0] bp_bus(input int k);
    logic [BUSW-1:0] b;
    b = '0;
    for (int j = 0; j < LANES; j++) begin
      b = put(b, 2*j,   16'(32*(k+1)), 16'(16*j));
      b = put(b, 2*j+1, 16'(16*j),     16'h0000);
    end
    return b;
  endfunction

  function automatic logic [BUSW-1:0] bp_exp(input int k);
    logic [BUSW-1:0] b;
    b = '0;
    for (int j = 0; j < LANES; j++) begin
      b = put(b, 2*j,   16'(2*(k+1)+j), 16'(j));
      b = put(b, 2*j+1, 16'(2*(k+1)-j), 16'(j));
    end
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [BUSW-1:0] sat_bus;
  logic [BUSW-1:0] bus;
  logic [BUSW-1:0] exp_bus;
  logic [BUSW-1:0] held;
  bit              have_held;
  int              sent;
  int              got;
  int              n;

  initial begin
    vecs[0] = '{"rnd_trunc_neg8",   0, 16'hFFF8, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[1] = '{"trunc_big",        0, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0FFF, 16'hF000, 16'h0000, 16'h0000};
    vecs[2] = '{"rnd_pos8",         1, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h0000};
    vecs[3] = '{"rnd_neg8",         1, 16'hFFF8, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[4] = '{"rnd_neg24",        1, 16'hFFE8, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[5] = '{"rnd_mixed",        1, 16'h0017, 16'hFFE9, 16'h0001, 16'h0001, 16'h0002, 16'hFFFF, 16'h0001, 16'hFFFF};
    vecs[6] = '{"noshift_plain",    2, 16'h1234, 16'h0001, 16'h0034, 16'h0002, 16'h1268, 16'h0003, 16'h1200, 16'hFFFF};
    vecs[7] = '{"sat_edges",        2, 16'h7FFF, 16'h8000, 16'h0001, 16'h0001, 16'h7FFF, 16'h8001, 16'h7FFE, 16'h8000};
    vecs[8] = '{"sat_neg",          2, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h8000, 16'h7FFF};

    sat_bus = put(put('0, 0, 16'h7FFF, 16'h8000), 1, 16'h0001, 16'h0001);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  BUSW'(ir[0]),  BUSW'(1'b1));
    check("rst_out_valid", BUSW'(ov[0]),  BUSW'(1'b0));
    check("rst_out_data",  od[0],         '0);
    check("rst_ovf",       BUSW'(ovf[2]), BUSW'(1'b0));
    check("rst_cnt",       BUSW'(cnt[0]), BUSW'(16'd0));

    // Three clipping beats, then reset while two are still in flight.
    tick();
    in_data = sat_bus; in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    check("pre_rst_cnt", BUSW'(cnt[0]), BUSW'(16'd1));
    check("pre_rst_ovf", BUSW'(ovf[2]), BUSW'(1'b1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", BUSW'(ov[0]),  BUSW'(1'b0));
    check("mid_rst_ovf",   BUSW'(ovf[2]), BUSW'(1'b0));
    check("mid_rst_cnt",   BUSW'(cnt[0]), BUSW'(16'd0));
    #2 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", BUSW'(ir[0]), BUSW'(1'b1));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_stale_beat", BUSW'(ov[0] | ov[2]), BUSW'(1'b0));
    end

    // Basic butterfly on lane 0.
    in_data  = put(put('0, 0, 16'h0100, 16'hFFF0), 1, 16'h0080, 16'h0010);
    exp_bus  = put(put('0, 0, 16'h0018, 16'h0000), 1, 16'h0008, 16'hFFFE);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("basic_valid", BUSW'(ov[0]), BUSW'(1'b1));
    check("basic_data",  od[0], exp_bus);
    tick();
    check("basic_cnt",   BUSW'(cnt[0]), BUSW'(16'd1));

    // Vector table, each vector placed on a different lane.
    for (int i = 0; i < 9; i++) begin
      int k;
      k        = 2 * (i % LANES);
      bus      = put(put('0, k, vecs[i].a_re, vecs[i].a_im), k+1, vecs[i].b_re, vecs[i].b_im);
      exp_bus  = put(put('0, k, vecs[i].s_re, vecs[i].s_im), k+1, vecs[i].d_re, vecs[i].d_im);
      in_data  = bus;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check(vecs[i].name, od[vecs[i].inst], exp_bus);
      tick();
    end

    // Sticky overflow: set, hold, set-beats-clear, clear, bubbles never set.
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_cleared", BUSW'(ovf[2]), BUSW'(1'b0));
    in_data = sat_bus; in_valid = 1'b1; tick(); in_valid = 1'b0; tick();
    check("ovf_set", BUSW'(ovf[2]), BUSW'(1'b1));
    repeat (3) tick();
    check("ovf_hold", BUSW'(ovf[2]), BUSW'(1'b1));
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_set_wins", BUSW'(ovf[2]), BUSW'(1'b1));
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_clr", BUSW'(ovf[2]), BUSW'(1'b0));
    repeat (3) tick();
    check("ovf_bubble", BUSW'(ovf[2]), BUSW'(1'b0));

    // Backpressure: 5 beats, out_ready low for cycles 3..6.
    do_reset();
    sent = 0; got = 0; have_held = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      out_ready = !(cyc >= 3 && cyc < 7);
      in_valid  = (sent < 5);
      in_data   = bp_bus(sent);
      @(negedge clk);
      if (!out_ready && ov[0]) begin
        check("bp_stall_ready", BUSW'(ir[0]), BUSW'(1'b0));
        if (have_held) check("bp_stall_stable", od[0], held);
        held = od[0];
        have_held = 1'b1;
      end else begin
        have_held = 1'b0;
      end
      if (ov[0] && out_ready) begin
        check("bp_beat", od[0], bp_exp(got));
        got++;
      end
      if (in_valid && ir[0]) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", BUSW'(got), BUSW'(5));
    check("bp_cnt",   BUSW'(cnt[0]), BUSW'(16'd5));

    // Counter wrap after 65536 transfers.
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1; n = 0;
    for (int cyc = 0; cyc < 70000; cyc++) begin
      @(negedge clk);
      if (ov[0] && out_ready) n++;
      if (n == 65536) break;
    end
    check("wrap_transfers", BUSW'(n), BUSW'(65536));
    check("wrap_pre", BUSW'(cnt[0]), BUSW'(16'hFFFF));
    tick();
    check("wrap_zero", BUSW'(cnt[0]), BUSW'(16'h0000));
    tick();
    check("wrap_one",  BUSW'(cnt[0]), BUSW'(16'h0001));
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
